// File: rtl/floor_req_queue.sv
// floor_req_queue: arrival-ordered floor request queue with direct access, push/pop-shift and dedup
module floor_req_queue #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter bit DEDUP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] head,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              dup
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_n [DEPTH];
  logic [DATA_W-1:0] rd;
  logic [ADDR_W:0] cnt_n, lo, wpos;
  logic do_pop, hit, ovf_n, dup_n;
  assign head   = mem[0];
  assign empty  = count == '0;
  assign full   = count == DEPTH_C;
  assign do_pop = pop && !empty;
  assign lo     = do_pop ? CW'(1) : '0;
  assign wpos   = do_pop ? count - 1'b1 : count;
  always_comb begin
    hit = 1'b0;
    rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DEDUP && CW'(i) >= lo && CW'(i) < count && mem[i] == data) hit = 1'b1;
      if (ADDR_W'(i) == addr) rd = mem[i];
    end
  end
  // the shift is applied first so a simultaneous push lands in the freshly shifted image
  always_comb begin
    mem_n = mem;
    cnt_n = count;
    ovf_n = 1'b0;
    dup_n = 1'b0;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      mem_n[DEPTH-1] = '0;
    end
    if (push) begin
      if (full && !do_pop) ovf_n = 1'b1;
      else if (hit) begin
        dup_n = 1'b1;
        cnt_n = do_pop ? count - 1'b1 : count;
      end else begin
        for (int i = 0; i < DEPTH; i++) if (CW'(i) == wpos) mem_n[i] = data;
        cnt_n = do_pop ? count : count + 1'b1;
      end
    end else if (do_pop) cnt_n = count - 1'b1;
    else if (we && !pop) begin
      for (int i = 0; i < DEPTH; i++) if (ADDR_W'(i) == addr) mem_n[i] = data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
      q     <= '0;
      ovf   <= 1'b0;
      dup   <= 1'b0;
    end else begin
      mem   <= mem_n;
      count <= cnt_n;
      q     <= rd;
      ovf   <= ovf_n;
      dup   <= dup_n;
    end
  end
endmodule

// File: tb/tb_floor_req_queue.sv
// tb_floor_req_queue: directed scenario checks for floor_req_queue
module tb_floor_req_queue;
  logic clk = 1'b0;
  logic rst, we, push, pop;
  logic [3:0] addr, data;
  logic [3:0] q, head;
  logic [4:0] count;
  logic empty, full, ovf, dup;
  int vec = 0;
  int errs = 0;

  floor_req_queue dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data(data), .push(push), .pop(pop),
    .q(q), .head(head), .count(count), .empty(empty), .full(full), .ovf(ovf), .dup(dup)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic push_val(input logic [3:0] v);
    push = 1'b1; data = v; step(); push = 1'b0;
  endtask

  task automatic test_reset();
    addr = 4'd0; data = 4'd0;
    do_reset();
    vec++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
    vec++; if (empty !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
    vec++; if (ovf !== 1'b0 || dup !== 1'b0) begin errs++; $display("FAIL reset_pulses got ovf=%b dup=%b exp 0 0", ovf, dup); end
    vec++; if (q !== 4'd0 || head !== 4'd0) begin errs++; $display("FAIL reset_data got q=%0d head=%0d exp 0 0", q, head); end
  endtask

  task automatic test_direct_write();
    do_reset();
    we = 1'b1; addr = 4'd2; data = 4'd10; step(); we = 1'b0;
    vec++; if (q !== 4'd0) begin errs++; $display("FAIL rbw_q got %0d exp 0", q); end
    step();
    vec++; if (q !== 4'd10) begin errs++; $display("FAIL wr_q got %0d exp 10", q); end
    vec++; if (count !== 5'd0 || empty !== 1'b1) begin errs++; $display("FAIL wr_count got %0d empty=%b exp 0 1", count, empty); end
    push_val(4'd10);
    vec++; if (dup !== 1'b0 || count !== 5'd1) begin errs++; $display("FAIL wr_invalid_dedup got dup=%b count=%0d exp 0 1", dup, count); end
  endtask

  task automatic test_push();
    do_reset();
    push_val(4'd8);
    push_val(4'd5);
    addr = 4'd1; step();
    vec++; if (head !== 4'd8) begin errs++; $display("FAIL push_head got %0d exp 8", head); end
    vec++; if (count !== 5'd2) begin errs++; $display("FAIL push_count got %0d exp 2", count); end
    vec++; if (q !== 4'd5) begin errs++; $display("FAIL push_q1 got %0d exp 5", q); end
  endtask

  task automatic test_pop();
    pop = 1'b1; step(); pop = 1'b0;
    vec++; if (head !== 4'd5 || count !== 5'd1) begin errs++; $display("FAIL pop_head got head=%0d count=%0d exp 5 1", head, count); end
    addr = 4'd1; step();
    vec++; if (q !== 4'd0) begin errs++; $display("FAIL pop_clear got %0d exp 0", q); end
    pop = 1'b1; step(); step(); pop = 1'b0;
    vec++; if (count !== 5'd0 || empty !== 1'b1) begin errs++; $display("FAIL pop_empty got count=%0d empty=%b exp 0 1", count, empty); end
    vec++; if (ovf !== 1'b0 || dup !== 1'b0 || head !== 4'd0) begin errs++; $display("FAIL pop_ignored got ovf=%b dup=%b head=%0d exp 0 0 0", ovf, dup, head); end
  endtask

  task automatic test_dedup();
    do_reset();
    push_val(4'd3);
    push_val(4'd7);
    push_val(4'd7);
    vec++; if (dup !== 1'b1 || count !== 5'd2) begin errs++; $display("FAIL dup_pulse got dup=%b count=%0d exp 1 2", dup, count); end
    step();
    vec++; if (dup !== 1'b0) begin errs++; $display("FAIL dup_clear got %b exp 0", dup); end
    push = 1'b1; pop = 1'b1; data = 4'd3; step(); idle();
    vec++; if (dup !== 1'b0 || head !== 4'd7 || count !== 5'd2) begin errs++; $display("FAIL dup_headx got dup=%b head=%0d count=%0d exp 0 7 2", dup, head, count); end
    addr = 4'd1; step();
    vec++; if (q !== 4'd3) begin errs++; $display("FAIL dup_headx_q got %0d exp 3", q); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_val(4'(i));
    vec++; if (full !== 1'b1 || count !== 5'd16) begin errs++; $display("FAIL full_flag got full=%b count=%0d exp 1 16", full, count); end
    push_val(4'd9);
    vec++; if (ovf !== 1'b1 || dup !== 1'b0 || count !== 5'd16) begin errs++; $display("FAIL ovf_pulse got ovf=%b dup=%b count=%0d exp 1 0 16", ovf, dup, count); end
    addr = 4'd15; step();
    vec++; if (ovf !== 1'b0 || q !== 4'd15 || head !== 4'd0) begin errs++; $display("FAIL ovf_nochange got ovf=%b q=%0d head=%0d exp 0 15 0", ovf, q, head); end
    // 9 is still queued behind the head, so the combined op pops but refuses the push
    push = 1'b1; pop = 1'b1; data = 4'd9; step(); idle();
    vec++; if (ovf !== 1'b0 || dup !== 1'b1 || count !== 5'd15 || head !== 4'd1) begin errs++; $display("FAIL full_pp_dup got ovf=%b dup=%b count=%0d head=%0d exp 0 1 15 1", ovf, dup, count, head); end
    push_val(4'd0);
    vec++; if (full !== 1'b1 || dup !== 1'b0) begin errs++; $display("FAIL refill got full=%b dup=%b exp 1 0", full, dup); end
    push = 1'b1; pop = 1'b1; data = 4'd1; step(); idle();
    vec++; if (ovf !== 1'b0 || dup !== 1'b0 || count !== 5'd16 || head !== 4'd2) begin errs++; $display("FAIL full_pp got ovf=%b dup=%b count=%0d head=%0d exp 0 0 16 2", ovf, dup, count, head); end
    addr = 4'd15; step();
    vec++; if (q !== 4'd1) begin errs++; $display("FAIL full_pp_tail got %0d exp 1", q); end
    addr = 4'd14; step();
    vec++; if (q !== 4'd0) begin errs++; $display("FAIL full_pp_prev got %0d exp 0", q); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push = 1'b1; pop = 1'b1; data = 4'd6; step(); idle();
    vec++; if (count !== 5'd1 || head !== 4'd6) begin errs++; $display("FAIL pp_empty got count=%0d head=%0d exp 1 6", count, head); end
    push = 1'b1; data = 4'd2; step(); data = 4'd4; step(); idle();
    vec++; if (count !== 5'd3 || head !== 4'd6) begin errs++; $display("FAIL b2b_push got count=%0d head=%0d exp 3 6", count, head); end
    addr = 4'd2; step();
    vec++; if (q !== 4'd4) begin errs++; $display("FAIL b2b_tail got %0d exp 4", q); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) push_val(4'(i));
    vec++; if (count !== 5'd5) begin errs++; $display("FAIL mid_fill got %0d exp 5", count); end
    rst = 1'b1; push = 1'b1; data = 4'd6; addr = 4'd0; step(); rst = 1'b0; idle();
    vec++; if (count !== 5'd0 || head !== 4'd0 || q !== 4'd0 || ovf !== 1'b0 || dup !== 1'b0) begin errs++; $display("FAIL mid_rst got count=%0d head=%0d q=%0d ovf=%b dup=%b exp all 0", count, head, q, ovf, dup); end
    for (int i = 1; i < 5; i++) begin
      addr = 4'(i); step();
      vec++; if (q !== 4'd0) begin errs++; $display("FAIL mid_rst_mem%0d got %0d exp 0", i, q); end
    end
    push_val(4'd4);
    push_val(4'd6);
    we = 1'b1; pop = 1'b1; addr = 4'd1; data = 4'd9; step(); idle();
    vec++; if (count !== 5'd1 || head !== 4'd6) begin errs++; $display("FAIL we_pop got count=%0d head=%0d exp 1 6", count, head); end
    step();
    vec++; if (q !== 4'd0) begin errs++; $display("FAIL we_dropped got %0d exp 0", q); end
  endtask

  initial begin
    rst = 1'b0; idle(); addr = '0; data = '0;
    test_reset();
    test_direct_write();
    test_push();
    test_pop();
    test_dedup();
    test_full();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
